lm_init_ctrl: RTL

Local-memory initialization controller and port arbiter for one 64-bit IRAM or DRAM bank of the evalsoc subsystem. After reset, or on command, it either zero-fills the whole bank or packs a little-endian byte stream from a loader into 64-bit line writes, then zero-fills the remaining lines. While it runs it owns the SRAM port and stalls the core. When idle, the core port passes straight through.

---
 rtl/lm_init_ctrl_if.sv | 45 ++++
 rtl/lm_init_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/lm_init_ctrl_if.sv
// Port bundle for lm_init_ctrl: init command, byte stream loader, core port and SRAM port.
// slave is the controller's view; master is the view of whatever surrounds it.
interface lm_init_ctrl_if #(
  parameter int AW = 13,
  parameter int DW = 64
);
  logic          init_start;
  logic          init_mode;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [7:0]    core_wem;
  logic          core_gnt;
  logic [DW-1:0] core_rdata;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [7:0]    ram_wem;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          done;
  logic          trunc;

  modport slave (
    input  init_start, init_mode, s_valid, s_data, s_last,
    input  core_req, core_we, core_addr, core_wdata, core_wem, ram_dout,
    output s_ready, core_gnt, core_rdata,
    output ram_cs, ram_we, ram_addr, ram_wdata, ram_wem,
    output busy, done, trunc
  );

  modport master (
    output init_start, init_mode, s_valid, s_data, s_last,
    output core_req, core_we, core_addr, core_wdata, core_wem, ram_dout,
    input  s_ready, core_gnt, core_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wdata, ram_wem,
    input  busy, done, trunc
  );
endinterface

// File: rtl/lm_init_ctrl.sv
// Bank init controller: zero-fills or stream-loads one 64-bit SRAM bank, else passes the core port through.
// Passthrough is same-cycle; while busy the core is stalled (no grant) and s_ready is up only in LOAD.
module lm_init_ctrl #(
  parameter int DP = 8192,
  parameter int AW = $clog2(DP)
) (
  input  logic          clk,
  input  logic          rst,
  lm_init_ctrl_if.slave bus
);
  localparam int            DW        = 64;
  localparam logic [AW-1:0] LAST_LINE = AW'(DP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_FILL,
    ST_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] line_ptr;
  logic [2:0]    byte_idx;
  logic [DW-1:0] pack;
  logic          last_seen;
  logic          trunc_q;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [7:0]    ram_wem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      line_ptr  <= '0;
      byte_idx  <= '0;
      pack      <= '0;
      last_seen <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.init_start) begin
            line_ptr  <= '0;
            byte_idx  <= '0;
            pack      <= '0;
            last_seen <= 1'b0;
            trunc_q   <= 1'b0;
            state     <= bus.init_mode ? ST_LOAD : ST_FILL;
          end
        end
        ST_LOAD: begin
          if (bus.s_valid) begin
            pack[{byte_idx, 3'b000} +: 8] <= bus.s_data;
            byte_idx <= byte_idx + 3'd1;
            if (bus.s_last) last_seen <= 1'b1;
            if (byte_idx == 3'd7 || bus.s_last) state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          pack     <= '0;
          byte_idx <= '0;
          // Running out of lines without having seen s_last means the stream was longer than the bank.
          if (line_ptr == LAST_LINE) begin
            state <= ST_DONE;
            if (!last_seen) trunc_q <= 1'b1;
          end else begin
            line_ptr <= line_ptr + 1'b1;
            state    <= last_seen ? ST_FILL : ST_LOAD;
          end
        end
        ST_FILL: begin
          if (line_ptr == LAST_LINE) state <= ST_DONE;
          else line_ptr <= line_ptr + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wem   = '0;
    case (state)
      ST_IDLE: begin
        ram_cs    = bus.core_req;
        ram_we    = bus.core_we;
        ram_addr  = bus.core_addr;
        ram_wdata = bus.core_wdata;
        ram_wem   = bus.core_wem;
      end
      ST_WRITE: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = line_ptr;
        ram_wdata = pack;
        ram_wem   = 8'hFF;
      end
      ST_FILL: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = line_ptr;
        ram_wem   = 8'hFF;
      end
      default: ;
    endcase
  end

  assign bus.ram_cs     = ram_cs;
  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;
  assign bus.ram_wem    = ram_wem;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.s_ready    = (state == ST_LOAD);
  assign bus.core_gnt   = (state == ST_IDLE) && bus.core_req;
  assign bus.core_rdata = bus.ram_dout;
  assign bus.trunc      = trunc_q;
endmodule
